// File: rtl/rs_alu_station.sv
// rs_alu_station: ALU reservation station that holds ops until operands arrive and issues one per cycle.
// Define RS_LSB_CDB_EN to add a second (load/store buffer) snoop bus.
`ifndef OP_LOG
`define OP_LOG 5
`endif
`ifndef ROB_LOG
`define ROB_LOG 4
`endif
`ifndef OP_NOP
`define OP_NOP {`OP_LOG{1'b0}}
`endif

module rs_alu_station #(
  parameter int RS_SIZE = 16,
  parameter int RS_LOG  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                clear,
  input  logic                iss_valid,
  input  logic [`OP_LOG-1:0]  iss_op,
  input  logic [31:0]         iss_Vj,
  input  logic [31:0]         iss_Vk,
  input  logic                iss_Qj_rdy,
  input  logic                iss_Qk_rdy,
  input  logic [`ROB_LOG-1:0] iss_Qj,
  input  logic [`ROB_LOG-1:0] iss_Qk,
  input  logic [31:0]         iss_Imm,
  input  logic [`ROB_LOG-1:0] iss_DestRob,
  input  logic [31:0]         iss_CurPC,
  output logic                rs_full,
  input  logic                cdb_enable,
  input  logic [31:0]         cdb_value,
  input  logic [`ROB_LOG-1:0] cdb_RobId,
  output logic                RS_valid,
  output logic [`OP_LOG-1:0]  RS_op,
  output logic [31:0]         RS_Vj,
  output logic [31:0]         RS_Vk,
  output logic [31:0]         RS_Imm,
  output logic [31:0]         RS_CurPC,
  output logic [`ROB_LOG-1:0] RS_DestRob
`ifdef RS_LSB_CDB_EN
  ,
  input  logic                lsb_enable,
  input  logic [31:0]         lsb_value,
  input  logic [`ROB_LOG-1:0] lsb_RobId
`endif
);

  logic [RS_SIZE-1:0]  busy;
  logic [RS_SIZE-1:0]  e_jrdy;
  logic [RS_SIZE-1:0]  e_krdy;
  logic [`OP_LOG-1:0]  e_op   [RS_SIZE];
  logic [31:0]         e_vj   [RS_SIZE];
  logic [31:0]         e_vk   [RS_SIZE];
  logic [31:0]         e_imm  [RS_SIZE];
  logic [31:0]         e_pc   [RS_SIZE];
  logic [`ROB_LOG-1:0] e_qj   [RS_SIZE];
  logic [`ROB_LOG-1:0] e_qk   [RS_SIZE];
  logic [`ROB_LOG-1:0] e_dest [RS_SIZE];

  logic [RS_SIZE-1:0]  j_hit;
  logic [RS_SIZE-1:0]  k_hit;
  logic [31:0]         j_val [RS_SIZE];
  logic [31:0]         k_val [RS_SIZE];
  logic                ins_j_hit;
  logic                ins_k_hit;
  logic [31:0]         ins_j_val;
  logic [31:0]         ins_k_val;

  logic                sel_found;
  logic [RS_LOG-1:0]   sel_idx;
  logic [RS_LOG-1:0]   free_idx;
  logic                do_insert;

  assign rs_full   = &busy;
  assign do_insert = iss_valid && !rs_full;

  // Tag match against the snoop buses; the ALU bus is checked last so it wins a double hit.
  always_comb begin
    j_hit     = '0;
    k_hit     = '0;
    ins_j_hit = 1'b0;
    ins_k_hit = 1'b0;
    ins_j_val = cdb_value;
    ins_k_val = cdb_value;
    for (int i = 0; i < RS_SIZE; i++) begin
      j_val[i] = cdb_value;
      k_val[i] = cdb_value;
`ifdef RS_LSB_CDB_EN
      if (lsb_enable && lsb_RobId == e_qj[i]) begin
        j_hit[i] = 1'b1;
        j_val[i] = lsb_value;
      end
      if (lsb_enable && lsb_RobId == e_qk[i]) begin
        k_hit[i] = 1'b1;
        k_val[i] = lsb_value;
      end
`endif
      if (cdb_enable && cdb_RobId == e_qj[i]) begin
        j_hit[i] = 1'b1;
        j_val[i] = cdb_value;
      end
      if (cdb_enable && cdb_RobId == e_qk[i]) begin
        k_hit[i] = 1'b1;
        k_val[i] = cdb_value;
      end
    end
`ifdef RS_LSB_CDB_EN
    if (lsb_enable && lsb_RobId == iss_Qj) begin
      ins_j_hit = 1'b1;
      ins_j_val = lsb_value;
    end
    if (lsb_enable && lsb_RobId == iss_Qk) begin
      ins_k_hit = 1'b1;
      ins_k_val = lsb_value;
    end
`endif
    if (cdb_enable && cdb_RobId == iss_Qj) begin
      ins_j_hit = 1'b1;
      ins_j_val = cdb_value;
    end
    if (cdb_enable && cdb_RobId == iss_Qk) begin
      ins_k_hit = 1'b1;
      ins_k_val = cdb_value;
    end
  end

  // Scan from the top down so the lowest index ends up selected.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy[i] && e_jrdy[i] && e_krdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = RS_LOG'(i);
      end
      if (!busy[i]) free_idx = RS_LOG'(i);
    end
  end

  // Entry payload; only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rdy && !clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !e_jrdy[i] && j_hit[i]) begin
          e_vj[i]   <= j_val[i];
          e_jrdy[i] <= 1'b1;
        end
        if (busy[i] && !e_krdy[i] && k_hit[i]) begin
          e_vk[i]   <= k_val[i];
          e_krdy[i] <= 1'b1;
        end
      end
      if (do_insert) begin
        e_op[free_idx]   <= iss_op;
        e_qj[free_idx]   <= iss_Qj;
        e_qk[free_idx]   <= iss_Qk;
        e_imm[free_idx]  <= iss_Imm;
        e_pc[free_idx]   <= iss_CurPC;
        e_dest[free_idx] <= iss_DestRob;
        e_jrdy[free_idx] <= iss_Qj_rdy || ins_j_hit;
        e_krdy[free_idx] <= iss_Qk_rdy || ins_k_hit;
        e_vj[free_idx]   <= (!iss_Qj_rdy && ins_j_hit) ? ins_j_val : iss_Vj;
        e_vk[free_idx]   <= (!iss_Qk_rdy && ins_k_hit) ? ins_k_val : iss_Vk;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      RS_valid   <= 1'b0;
      RS_op      <= `OP_NOP;
      RS_Vj      <= '0;
      RS_Vk      <= '0;
      RS_Imm     <= '0;
      RS_CurPC   <= '0;
      RS_DestRob <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy       <= '0;
        RS_valid   <= 1'b0;
        RS_op      <= `OP_NOP;
        RS_Vj      <= '0;
        RS_Vk      <= '0;
        RS_Imm     <= '0;
        RS_CurPC   <= '0;
        RS_DestRob <= '0;
      end else begin
        if (sel_found) begin
          busy[sel_idx] <= 1'b0;
          RS_valid      <= 1'b1;
          RS_op         <= e_op[sel_idx];
          RS_Vj         <= e_vj[sel_idx];
          RS_Vk         <= e_vk[sel_idx];
          RS_Imm        <= e_imm[sel_idx];
          RS_CurPC      <= e_pc[sel_idx];
          RS_DestRob    <= e_dest[sel_idx];
        end else begin
          RS_valid <= 1'b0;
          RS_op    <= `OP_NOP;
        end
        // The insert slot is always a free entry, never the one being dispatched.
        if (do_insert) busy[free_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu_station.sv
// tb_rs_alu_station: directed and randomized checks of rs_alu_station against a behavioural queue model.
`ifndef OP_LOG
`define OP_LOG 5
`endif
`ifndef ROB_LOG
`define ROB_LOG 4
`endif

module tb_rs_alu_station;
  localparam int OPW  = `OP_LOG;
  localparam int ROBW = `ROB_LOG;
  localparam int N    = 16;
  localparam logic [OPW-1:0] OP_NOP = '0;
  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR = OPW'(3);

  logic            clk, rst_n, rdy, clear;
  logic            iss_valid, iss_Qj_rdy, iss_Qk_rdy;
  logic [OPW-1:0]  iss_op;
  logic [31:0]     iss_Vj, iss_Vk, iss_Imm, iss_CurPC;
  logic [ROBW-1:0] iss_Qj, iss_Qk, iss_DestRob;
  logic            rs_full;
  logic            cdb_enable;
  logic [31:0]     cdb_value;
  logic [ROBW-1:0] cdb_RobId;
  logic            RS_valid;
  logic [OPW-1:0]  RS_op;
  logic [31:0]     RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
  logic [ROBW-1:0] RS_DestRob;
`ifdef RS_LSB_CDB_EN
  logic            lsb_enable;
  logic [31:0]     lsb_value;
  logic [ROBW-1:0] lsb_RobId;
`endif

  rs_alu_station dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_Vj(iss_Vj), .iss_Vk(iss_Vk),
    .iss_Qj_rdy(iss_Qj_rdy), .iss_Qk_rdy(iss_Qk_rdy), .iss_Qj(iss_Qj), .iss_Qk(iss_Qk),
    .iss_Imm(iss_Imm), .iss_DestRob(iss_DestRob), .iss_CurPC(iss_CurPC),
    .rs_full(rs_full), .cdb_enable(cdb_enable), .cdb_value(cdb_value), .cdb_RobId(cdb_RobId),
    .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk), .RS_Imm(RS_Imm),
    .RS_CurPC(RS_CurPC), .RS_DestRob(RS_DestRob)
`ifdef RS_LSB_CDB_EN
    , .lsb_enable(lsb_enable), .lsb_value(lsb_value), .lsb_RobId(lsb_RobId)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            busy;
    logic [OPW-1:0]  op;
    logic [31:0]     vj, vk, imm, pc;
    logic [ROBW-1:0] qj, qk, dest;
    logic            jr, kr;
  } ent_t;

  ent_t            m [N];
  logic            e_valid;
  logic [OPW-1:0]  e_op;
  logic [31:0]     e_vj, e_vk, e_imm, e_pc;
  logic [ROBW-1:0] e_dest;
  int              errors;
  int              checks;

  function automatic logic model_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // A bus match on tag q; the ALU bus takes priority.
  function automatic logic snoop(input logic [ROBW-1:0] q, output logic [31:0] v);
    v = 32'd0;
    if (cdb_enable && cdb_RobId == q) begin
      v = cdb_value;
      return 1'b1;
    end
`ifdef RS_LSB_CDB_EN
    if (lsb_enable && lsb_RobId == q) begin
      v = lsb_value;
      return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i].busy = 1'b0;
    e_valid = 1'b0; e_op = OP_NOP; e_vj = 0; e_vk = 0; e_imm = 0; e_pc = 0; e_dest = '0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int sel, fr;
    logic full, hit;
    logic [31:0] v;
    if (!rdy) return;
    if (clear) begin
      model_reset();
      return;
    end
    full = model_full();
    sel = -1;
    fr = -1;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m[i].busy && m[i].jr && m[i].kr) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    if (sel >= 0) begin
      e_valid = 1'b1; e_op = m[sel].op; e_vj = m[sel].vj; e_vk = m[sel].vk;
      e_imm = m[sel].imm; e_pc = m[sel].pc; e_dest = m[sel].dest;
    end else begin
      e_valid = 1'b0; e_op = OP_NOP;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && !m[i].jr) begin
        hit = snoop(m[i].qj, v);
        if (hit) begin m[i].vj = v; m[i].jr = 1'b1; end
      end
      if (m[i].busy && !m[i].kr) begin
        hit = snoop(m[i].qk, v);
        if (hit) begin m[i].vk = v; m[i].kr = 1'b1; end
      end
    end
    if (sel >= 0) m[sel].busy = 1'b0;
    if (iss_valid && !full) begin
      m[fr].busy = 1'b1; m[fr].op = iss_op; m[fr].imm = iss_Imm; m[fr].pc = iss_CurPC;
      m[fr].dest = iss_DestRob; m[fr].qj = iss_Qj; m[fr].qk = iss_Qk;
      m[fr].jr = iss_Qj_rdy; m[fr].vj = iss_Vj; m[fr].kr = iss_Qk_rdy; m[fr].vk = iss_Vk;
      if (!iss_Qj_rdy) begin
        hit = snoop(iss_Qj, v);
        if (hit) begin m[fr].jr = 1'b1; m[fr].vj = v; end
      end
      if (!iss_Qk_rdy) begin
        hit = snoop(iss_Qk, v);
        if (hit) begin m[fr].kr = 1'b1; m[fr].vk = v; end
      end
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; clear = 1'b0; iss_valid = 1'b0; cdb_enable = 1'b0;
`ifdef RS_LSB_CDB_EN
    lsb_enable = 1'b0;
`endif
  endtask

  task automatic set_issue(input logic [OPW-1:0] op, input logic [31:0] vj, input logic jr,
                           input logic [ROBW-1:0] qj, input logic [31:0] vk, input logic kr,
                           input logic [ROBW-1:0] qk, input logic [31:0] imm,
                           input logic [ROBW-1:0] dest, input logic [31:0] pc);
    iss_valid = 1'b1; iss_op = op; iss_Vj = vj; iss_Qj_rdy = jr; iss_Qj = qj;
    iss_Vk = vk; iss_Qk_rdy = kr; iss_Qk = qk; iss_Imm = imm; iss_DestRob = dest; iss_CurPC = pc;
  endtask

  task automatic broadcast(input logic [ROBW-1:0] id, input logic [31:0] val);
    cdb_enable = 1'b1; cdb_RobId = id; cdb_value = val;
  endtask

  // One clock edge: update the model with the current inputs, then settle just past the edge.
  task automatic applyStimulus();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (RS_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", RS_valid); end
    checks++; if (RS_op !== OP_NOP) begin errors++; $display("[TB] FAIL reset_op: got %0h want %0h", RS_op, OP_NOP); end
    checks++; if (RS_Vj !== 32'd0) begin errors++; $display("[TB] FAIL reset_vj: got %0h want 0", RS_Vj); end
    checks++; if (RS_DestRob !== '0) begin errors++; $display("[TB] FAIL reset_dest: got %0h want 0", RS_DestRob); end
    checks++; if (rs_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %0b want 0", rs_full); end
    rst_n = 1'b1;
    model_reset();
    applyStimulus();
  endtask

  task automatic test_add();
    set_issue(OP_ADD, 32'd5, 1'b1, '0, 32'd7, 1'b1, '0, 32'h100, ROBW'(3), 32'h4000);
    applyStimulus(); idle_inputs();
    checks++; if (RS_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_insert_valid: got %0b want 0", RS_valid); end
    applyStimulus();
    checks++; if (RS_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %0b want 1", RS_valid); end
    checks++; if (RS_op !== OP_ADD) begin errors++; $display("[TB] FAIL add_op: got %0h want %0h", RS_op, OP_ADD); end
    checks++; if (RS_Vj !== 32'd5 || RS_Vk !== 32'd7) begin errors++; $display("[TB] FAIL add_operands: got %0h/%0h want 5/7", RS_Vj, RS_Vk); end
    checks++; if (RS_DestRob !== ROBW'(3)) begin errors++; $display("[TB] FAIL add_dest: got %0h want 3", RS_DestRob); end
    checks++; if (RS_Imm !== 32'h100 || RS_CurPC !== 32'h4000) begin errors++; $display("[TB] FAIL add_imm_pc: got %0h/%0h want 100/4000", RS_Imm, RS_CurPC); end
    applyStimulus();
    checks++; if (RS_valid !== 1'b0 || RS_op !== OP_NOP) begin errors++; $display("[TB] FAIL add_after: got valid %0b op %0h want 0/0", RS_valid, RS_op); end
    checks++; if (RS_Vj !== 32'd5) begin errors++; $display("[TB] FAIL add_hold_vj: got %0h want 5", RS_Vj); end
  endtask

  task automatic test_wakeup();
    set_issue(OP_SUB, 32'd0, 1'b0, ROBW'(2), 32'd9, 1'b1, '0, 32'd0, ROBW'(4), 32'h4004);
    applyStimulus(); idle_inputs();
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checks++; if (RS_valid !== 1'b0) begin errors++; $display("[TB] FAIL wake_wait%0d: got %0b want 0", c, RS_valid); end
    end
    broadcast(ROBW'(2), 32'h10);
    applyStimulus(); idle_inputs();
    checks++; if (RS_valid !== 1'b0) begin errors++; $display("[TB] FAIL wake_edge1: got %0b want 0", RS_valid); end
    applyStimulus();
    checks++; if (RS_valid !== 1'b1 || RS_op !== OP_SUB) begin errors++; $display("[TB] FAIL wake_edge2: got valid %0b op %0h want 1/%0h", RS_valid, RS_op, OP_SUB); end
    checks++; if (RS_Vj !== 32'h10 || RS_Vk !== 32'd9) begin errors++; $display("[TB] FAIL wake_operands: got %0h/%0h want 10/9", RS_Vj, RS_Vk); end
    checks++; if (RS_DestRob !== ROBW'(4)) begin errors++; $display("[TB] FAIL wake_dest: got %0h want 4", RS_DestRob); end
  endtask

  task automatic test_bypass();
    set_issue(OP_XOR, 32'h11, 1'b1, '0, 32'd0, 1'b0, ROBW'(6), 32'd0, ROBW'(5), 32'h4008);
    broadcast(ROBW'(6), 32'hABCD);
    applyStimulus(); idle_inputs();
    checks++; if (RS_valid !== 1'b0) begin errors++; $display("[TB] FAIL bypass_insert: got %0b want 0", RS_valid); end
    applyStimulus();
    checks++; if (RS_valid !== 1'b1 || RS_Vk !== 32'hABCD) begin errors++; $display("[TB] FAIL bypass_vk: got valid %0b vk %0h want 1/abcd", RS_valid, RS_Vk); end
    checks++; if (RS_Vj !== 32'h11 || RS_DestRob !== ROBW'(5)) begin errors++; $display("[TB] FAIL bypass_fields: got %0h/%0h want 11/5", RS_Vj, RS_DestRob); end
    applyStimulus();
    checks++; if (RS_valid !== 1'b0) begin errors++; $display("[TB] FAIL bypass_drain: got %0b want 0", RS_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < N; i++) begin
      set_issue(OP_ADD, 32'd0, 1'b0, ROBW'(1), 32'(i), 1'b1, '0, 32'd0, ROBW'(i), 32'h5000);
      applyStimulus();
    end
    idle_inputs();
    checks++; if (rs_full !== 1'b1) begin errors++; $display("[TB] FAIL full_set: got %0b want 1", rs_full); end
    set_issue(OP_XOR, 32'd1, 1'b1, '0, 32'd1, 1'b1, '0, 32'd0, ROBW'(15), 32'h6000);
    applyStimulus(); idle_inputs();
    checks++; if (rs_full !== 1'b1 || RS_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drop: got full %0b valid %0b want 1/0", rs_full, RS_valid); end
    broadcast(ROBW'(1), 32'h77);
    applyStimulus(); idle_inputs();
    checks++; if (rs_full !== 1'b1 || RS_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_wake: got full %0b valid %0b want 1/0", rs_full, RS_valid); end
    for (int k = 0; k < N; k++) begin
      applyStimulus();
      checks++;
      if (RS_valid !== 1'b1 || RS_DestRob !== ROBW'(k) || RS_Vj !== 32'h77 || RS_Vk !== 32'(k)) begin
        errors++;
        $display("[TB] FAIL full_order%0d: got valid %0b dest %0h vj %0h vk %0h want 1/%0h/77/%0h", k, RS_valid, RS_DestRob, RS_Vj, RS_Vk, k, k);
      end
      if (k == 0) begin
        checks++; if (rs_full !== 1'b0) begin errors++; $display("[TB] FAIL full_drop_after_first: got %0b want 0", rs_full); end
      end
    end
    applyStimulus();
    checks++; if (RS_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_extra_dropped: got %0b want 0", RS_valid); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) begin
      set_issue(OP_SUB, 32'd0, 1'b0, ROBW'(9), 32'd3, 1'b1, '0, 32'd0, ROBW'(i), 32'h7000);
      applyStimulus();
    end
    set_issue(OP_ADD, 32'd1, 1'b1, '0, 32'd2, 1'b1, '0, 32'd0, ROBW'(7), 32'h7100);
    broadcast(ROBW'(9), 32'h55);
    clear = 1'b1;
    applyStimulus(); idle_inputs();
    checks++; if (RS_valid !== 1'b0 || RS_op !== OP_NOP) begin errors++; $display("[TB] FAIL clear_out: got valid %0b op %0h want 0/0", RS_valid, RS_op); end
    checks++; if (RS_Vj !== 32'd0 || rs_full !== 1'b0) begin errors++; $display("[TB] FAIL clear_zero: got vj %0h full %0b want 0/0", RS_Vj, rs_full); end
    broadcast(ROBW'(9), 32'h56);
    for (int c = 0; c < 4; c++) begin
      applyStimulus();
      checks++; if (RS_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_no_dispatch%0d: got %0b want 0", c, RS_valid); end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      rdy = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 63) == 0);
      if (!model_full() && $urandom_range(0, 1) == 1)
        set_issue(OPW'($urandom), $urandom, 1'($urandom), ROBW'($urandom_range(0, 7)),
                  $urandom, 1'($urandom), ROBW'($urandom_range(0, 7)), $urandom,
                  ROBW'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1) broadcast(ROBW'($urandom_range(0, 7)), $urandom);
`ifdef RS_LSB_CDB_EN
      lsb_enable = 1'($urandom);
      lsb_RobId = ROBW'($urandom_range(0, 7));
      lsb_value = $urandom;
`endif
      applyStimulus();
      checks++;
      if (RS_valid !== e_valid || RS_op !== e_op || RS_DestRob !== e_dest) begin
        errors++;
        $display("[TB] FAIL rand_ctl%0d: got valid %0b op %0h dest %0h want %0b/%0h/%0h", c, RS_valid, RS_op, RS_DestRob, e_valid, e_op, e_dest);
      end
      checks++;
      if (RS_Vj !== e_vj || RS_Vk !== e_vk || RS_Imm !== e_imm || RS_CurPC !== e_pc) begin
        errors++;
        $display("[TB] FAIL rand_data%0d: got %0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h", c, RS_Vj, RS_Vk, RS_Imm, RS_CurPC, e_vj, e_vk, e_imm, e_pc);
      end
      checks++;
      if (rs_full !== model_full()) begin errors++; $display("[TB] FAIL rand_full%0d: got %0b want %0b", c, rs_full, model_full()); end
    end
    idle_inputs();
  endtask

  task automatic test_rdy_hold();
    clear = 1'b1;
    applyStimulus(); idle_inputs();
    set_issue(OP_ADD, 32'hA1, 1'b1, '0, 32'hB1, 1'b1, '0, 32'd0, ROBW'(10), 32'h8000);
    applyStimulus();
    set_issue(OP_SUB, 32'hA2, 1'b1, '0, 32'hB2, 1'b1, '0, 32'd0, ROBW'(11), 32'h8004);
    applyStimulus(); idle_inputs();
    checks++; if (RS_valid !== 1'b1 || RS_DestRob !== ROBW'(10)) begin errors++; $display("[TB] FAIL hold_pre: got valid %0b dest %0h want 1/a", RS_valid, RS_DestRob); end
    rdy = 1'b0;
    broadcast(ROBW'(0), 32'hDEAD);
    set_issue(OP_XOR, 32'hA3, 1'b1, '0, 32'hB3, 1'b1, '0, 32'd0, ROBW'(12), 32'h8008);
    for (int c = 0; c < 4; c++) begin
      applyStimulus();
      checks++;
      if (RS_valid !== 1'b1 || RS_DestRob !== ROBW'(10) || RS_Vj !== 32'hA1) begin
        errors++;
        $display("[TB] FAIL hold%0d: got valid %0b dest %0h vj %0h want 1/a/a1", c, RS_valid, RS_DestRob, RS_Vj);
      end
    end
    idle_inputs();
    applyStimulus();
    checks++; if (RS_valid !== 1'b1 || RS_DestRob !== ROBW'(11) || RS_Vj !== 32'hA2) begin errors++; $display("[TB] FAIL hold_resume: got valid %0b dest %0h vj %0h want 1/b/a2", RS_valid, RS_DestRob, RS_Vj); end
    rdy = 1'b0;
    #4;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (RS_valid !== 1'b0 || RS_op !== OP_NOP) begin errors++; $display("[TB] FAIL async_ctl: got valid %0b op %0h want 0/0", RS_valid, RS_op); end
    checks++; if (RS_Vj !== 32'd0 || RS_DestRob !== '0 || rs_full !== 1'b0) begin errors++; $display("[TB] FAIL async_data: got vj %0h dest %0h full %0b want 0/0/0", RS_Vj, RS_DestRob, rs_full); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    iss_op = OP_NOP; iss_Vj = 0; iss_Vk = 0; iss_Qj_rdy = 1'b1; iss_Qk_rdy = 1'b1;
    iss_Qj = '0; iss_Qk = '0; iss_Imm = 0; iss_DestRob = '0; iss_CurPC = 0;
    cdb_value = 0; cdb_RobId = '0;
`ifdef RS_LSB_CDB_EN
    lsb_value = 0; lsb_RobId = '0;
`endif
    idle_inputs();
    test_reset();
    test_add();
    test_wakeup();
    test_bypass();
    test_full();
    test_clear();
    test_random();
    test_rdy_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
